// File: rtl/icache_mshr_allocator.sv
// icache MSHR entry pool allocator.
// Tracks free entries in a bitmap and offers one pre-selected free index per
// cycle. Every offer output comes straight from a flop, so the consumer may
// make alloc_rdy depend on alloc_vld without forming a combinational loop.
// Entries come back on refill release or on flush. A prefetch reserve keeps
// PF_RSV entries available for demand and snoop traffic.
module icache_mshr_allocator #(
  parameter int ENTRY_NUM   = 8,
  parameter int INDEX_WIDTH = $clog2(ENTRY_NUM),
  parameter int PF_RSV      = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   alloc_vld,
  output logic [INDEX_WIDTH-1:0] alloc_index,
  input  logic                   alloc_rdy,
  output logic                   pf_alloc_ok,
  input  logic                   rel_vld,
  input  logic [INDEX_WIDTH-1:0] rel_index,
  input  logic                   flush,
  output logic [INDEX_WIDTH:0]   free_cnt,
  output logic                   mshr_full,
  output logic                   mshr_empty,
  output logic                   rel_err
);

  localparam int                CNT_W    = INDEX_WIDTH + 1;
  localparam logic [CNT_W-1:0] ENTRY_C  = CNT_W'(ENTRY_NUM);
  localparam logic [CNT_W-1:0] PF_RSV_C = CNT_W'(PF_RSV);

  logic [ENTRY_NUM-1:0]   free_mask, mask_n;
  logic [CNT_W-1:0]       cnt_q, cnt_n;
  logic                   alloc_vld_q;
  logic [INDEX_WIDTH-1:0] alloc_index_q, idx_n;
  logic                   pf_ok_q, full_q, empty_q, rel_err_q;

  logic alloc_fire;
  logic rel_in_range;
  logic rel_bad;
  logic rel_ok;

  assign alloc_fire = alloc_vld_q && alloc_rdy;

  // A release is rejected when its index is out of range or the entry is
  // already free. That covers releasing the entry being accepted this cycle,
  // because an offered entry is free by construction.
  assign rel_in_range = ({1'b0, rel_index} < ENTRY_C);
  assign rel_bad      = rel_vld && (!rel_in_range || free_mask[rel_index]);
  assign rel_ok       = rel_vld && !rel_bad;

  // Next-state bitmap, count and lowest-free selection for the next offer.
  always_comb begin
    // NOTE: every variable written here receives a default value first, so no path can leave one unassigned and infer a latch.
    mask_n = free_mask;
    cnt_n  = cnt_q;
    idx_n  = '0;
    if (alloc_fire) mask_n[alloc_index_q] = 1'b0;
    if (rel_ok)     mask_n[rel_index]     = 1'b1;
    cnt_n = cnt_q + CNT_W'(rel_ok) - CNT_W'(alloc_fire);
    // Flush wins over accept and release in the same cycle, so an entry
    // accepted in the flush cycle ends up free again.
    if (flush) begin
      mask_n = '1;
      cnt_n  = ENTRY_C;
    end
    // Scan downward so the lowest set bit is the last one written.
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (mask_n[i]) idx_n = i[INDEX_WIDTH-1:0];
    end
  end

  // Pool state and registered offer/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the free bitmap is a small flop vector, not a RAM, so it is reset directly to all-free.
      free_mask     <= '1;
      cnt_q         <= ENTRY_C;
      alloc_vld_q   <= 1'b0;
      alloc_index_q <= '0;
      pf_ok_q       <= 1'b0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      rel_err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge state, so no ordering race arises between them.
      free_mask     <= mask_n;
      cnt_q         <= cnt_n;
      alloc_vld_q   <= |mask_n;
      alloc_index_q <= idx_n;
      pf_ok_q       <= (cnt_n > PF_RSV_C);
      full_q        <= (cnt_n == '0);
      empty_q       <= (cnt_n == ENTRY_C);
      if (rel_bad) rel_err_q <= 1'b1;
    end
  end

  assign alloc_vld   = alloc_vld_q;
  assign alloc_index = alloc_index_q;
  assign pf_alloc_ok = pf_ok_q;
  assign free_cnt    = cnt_q;
  assign mshr_full   = full_q;
  assign mshr_empty  = empty_q;
  assign rel_err     = rel_err_q;

endmodule

// File: tb/tb_icache_mshr_allocator.sv
// Directed testbench for icache_mshr_allocator (ENTRY_NUM=8, PF_RSV=2).
// Inputs change 1 time unit after a rising edge. Outputs are checked at that
// same point, which is away from the active edge.
module tb_icache_mshr_allocator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_vld;
  logic [2:0] alloc_index;
  logic       alloc_rdy;
  logic       pf_alloc_ok;
  logic       rel_vld;
  logic [2:0] rel_index;
  logic       flush;
  logic [3:0] free_cnt;
  logic       mshr_full;
  logic       mshr_empty;
  logic       rel_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  icache_mshr_allocator #(.ENTRY_NUM(8), .INDEX_WIDTH(3), .PF_RSV(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_vld   (alloc_vld),
    .alloc_index (alloc_index),
    .alloc_rdy   (alloc_rdy),
    .pf_alloc_ok (pf_alloc_ok),
    .rel_vld     (rel_vld),
    .rel_index   (rel_index),
    .flush       (flush),
    .free_cnt    (free_cnt),
    .mshr_full   (mshr_full),
    .mshr_empty  (mshr_empty),
    .rel_err     (rel_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " alloc_vld"},   32'(alloc_vld),   32'd0);
    check({tag, " alloc_index"}, 32'(alloc_index), 32'd0);
    check({tag, " pf_ok"},       32'(pf_alloc_ok), 32'd0);
    check({tag, " full"},        32'(mshr_full),   32'd0);
    check({tag, " empty"},       32'(mshr_empty),  32'd1);
    check({tag, " free_cnt"},    32'(free_cnt),    32'd8);
    check({tag, " rel_err"},     32'(rel_err),     32'd0);
  endtask

  initial begin
    logic [3:0] idx_nine;
    rst_n     = 1'b0;
    alloc_rdy = 1'b0;
    rel_vld   = 1'b0;
    rel_index = '0;
    flush     = 1'b0;
    #12;
    check_reset_values("rst");
    step();
    rst_n = 1'b1;
    step();
    check("first vld",   32'(alloc_vld),   32'd1);
    check("first idx",   32'(alloc_index), 32'd0);
    check("first pf",    32'(pf_alloc_ok), 32'd1);
    check("first empty", 32'(mshr_empty),  32'd1);

    // Eight back-to-back accepts drain the pool in index order.
    alloc_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain idx%0d", i), 32'(alloc_index), 32'(i));
      check($sformatf("drain vld%0d", i), 32'(alloc_vld), 32'd1);
      step();
      check($sformatf("drain cnt%0d", i), 32'(free_cnt), 32'(7 - i));
    end
    check("full flag", 32'(mshr_full), 32'd1);
    check("full vld",  32'(alloc_vld), 32'd0);
    check("full pf",   32'(pf_alloc_ok), 32'd0);
    step();  // alloc_rdy is still high but there is nothing to accept
    check("full rdy ignored cnt", 32'(free_cnt),  32'd0);
    check("full rdy ignored vld", 32'(alloc_vld), 32'd0);
    alloc_rdy = 1'b0;

    // Release entry 5 while full: it is offered on the next cycle.
    rel_vld = 1'b1; rel_index = 3'd5;
    step();
    rel_vld = 1'b0;
    check("rel5 vld",  32'(alloc_vld),   32'd1);
    check("rel5 idx",  32'(alloc_index), 32'd5);
    check("rel5 cnt",  32'(free_cnt),    32'd1);
    check("rel5 pf",   32'(pf_alloc_ok), 32'd0);
    check("rel5 full", 32'(mshr_full),   32'd0);

    // Free 6 and 7, then accept 5, leaving free = {6,7}.
    rel_vld = 1'b1; rel_index = 3'd6; step();
    rel_index = 3'd7; step();
    rel_vld = 1'b0;
    check("free3 cnt", 32'(free_cnt),    32'd3);
    check("free3 pf",  32'(pf_alloc_ok), 32'd1);
    alloc_rdy = 1'b1; step(); alloc_rdy = 1'b0;
    check("free2 cnt", 32'(free_cnt),    32'd2);
    check("free2 pf",  32'(pf_alloc_ok), 32'd0);
    check("free2 idx", 32'(alloc_index), 32'd6);

    // Accept 6 and release 2 in the same cycle: count holds, 2 is offered next.
    alloc_rdy = 1'b1; rel_vld = 1'b1; rel_index = 3'd2;
    step();
    alloc_rdy = 1'b0; rel_vld = 1'b0;
    check("swap cnt", 32'(free_cnt),    32'd2);
    check("swap idx", 32'(alloc_index), 32'd2);
    check("swap err", 32'(rel_err),     32'd0);

    // Release 3 to cross the prefetch reserve: free = {2,3,7}.
    rel_vld = 1'b1; rel_index = 3'd3; step(); rel_vld = 1'b0;
    check("pf cross cnt", 32'(free_cnt),    32'd3);
    check("pf cross ok",  32'(pf_alloc_ok), 32'd1);

    // Valid release of 4, then a second release of 4 while it is already free.
    rel_vld = 1'b1; rel_index = 3'd4; step();
    check("rel4 cnt", 32'(free_cnt), 32'd4);
    check("rel4 err", 32'(rel_err),  32'd0);
    step();
    rel_vld = 1'b0;
    check("dbl rel err", 32'(rel_err),  32'd1);
    check("dbl rel cnt", 32'(free_cnt), 32'd4);
    step();
    check("err sticky", 32'(rel_err), 32'd1);

    // Accept 2 so that 5 entries are in use, then flush with an accept in that cycle.
    alloc_rdy = 1'b1; step();
    check("pre flush cnt", 32'(free_cnt),    32'd3);
    check("pre flush idx", 32'(alloc_index), 32'd3);
    flush = 1'b1;
    step();
    flush = 1'b0; alloc_rdy = 1'b0;
    check("flush cnt",   32'(free_cnt),    32'd8);
    check("flush idx",   32'(alloc_index), 32'd0);
    check("flush empty", 32'(mshr_empty),  32'd1);
    check("flush vld",   32'(alloc_vld),   32'd1);
    check("flush err",   32'(rel_err),     32'd1);

    // Reset asserted mid-run takes effect without waiting for a clock edge.
    alloc_rdy = 1'b1; step(); step();
    alloc_rdy = 1'b0;
    check("mid cnt", 32'(free_cnt), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async rst");
    step();
    rst_n = 1'b1;
    step();

    // Index 9 does not fit in 3 bits and truncates to 1. Entry 1 is free,
    // so the release is still rejected.
    idx_nine  = 4'd9;
    rel_vld   = 1'b1;
    rel_index = idx_nine[2:0];
    step();
    rel_vld = 1'b0;
    check("idx9 err", 32'(rel_err),  32'd1);
    check("idx9 cnt", 32'(free_cnt), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
